// File: rtl/m8_frame_loader.sv
// Purpose: packs a valid/ready byte stream into 8-slot frames for the m8 descending sorter.
// Latency: out_valid rises one clock after the accept that completes a frame (8th element or in_last).
// Backpressure: in_ready drops while a frame is held; the frame is held until out_valid && out_ready.
module m8_frame_loader #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic             flush,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [WIDTH-1:0] out_e,
    output logic [WIDTH-1:0] out_f,
    output logic [WIDTH-1:0] out_g,
    output logic [WIDTH-1:0] out_h,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_short,
    output logic [3:0]       count,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] slot [8];
    logic             accept;
    logic             transfer;
    logic             frame_end;

    // in_ready is a function of state and flush only (reset forces it low), never of in_valid.
    assign in_ready  = (state == FILL) && !flush && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign transfer  = out_valid && out_ready;
    // The accept at count==7 is the 8th element; in_last closes the frame early.
    assign frame_end = accept && ((count == 4'd7) || in_last);

    assign out_a = slot[0];
    assign out_b = slot[1];
    assign out_c = slot[2];
    assign out_d = slot[3];
    assign out_e = slot[4];
    assign out_f = slot[5];
    assign out_g = slot[6];
    assign out_h = slot[7];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: FILL closes a frame on its final accept; HOLD releases on the output handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (frame_end) state_nxt = HOLD;
            HOLD: if (transfer)  state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Slot/count/flag datapath: fill in arrival order, zero on flush or release, count releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) slot[i] <= '0;
            count     <= 4'd0;
            out_short <= 1'b0;
            frame_cnt <= '0;
        end else if (state == FILL) begin
            if (flush) begin
                for (int i = 0; i < 8; i++) slot[i] <= '0;
                count <= 4'd0;
            end else if (accept) begin
                slot[count[2:0]] <= in_data;
                count            <= count + 4'd1;
                if (frame_end) out_short <= (count != 4'd7);
            end
        end else if (transfer) begin
            for (int i = 0; i < 8; i++) slot[i] <= '0;
            count     <= 4'd0;
            out_short <= 1'b0;
            frame_cnt <= frame_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_m8_frame_loader.sv
// Purpose: directed bench for m8_frame_loader with a reduced 4-bit frame counter.
// Latency: drives inputs 1ns after each rising edge and samples outputs at that same point.
// Backpressure: holds out_ready low to stall frames and checks the stream is blocked.
module tb_m8_frame_loader;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic             flush;
    logic [WIDTH-1:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
    logic             out_valid;
    logic             out_ready;
    logic             out_short;
    logic [3:0]       count;
    logic [CNT_W-1:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    m8_frame_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .flush(flush),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .out_e(out_e), .out_f(out_f), .out_g(out_g), .out_h(out_h),
        .out_valid(out_valid), .out_ready(out_ready), .out_short(out_short),
        .count(count), .frame_cnt(frame_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [63:0] exp);
        chk(tag, {out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h}, exp);
    endtask

    // One element offered for exactly one cycle; assumes the loader is in FILL.
    task automatic send(input logic [7:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #12;
        // Reset state
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_out_short", out_short, 0);
        chk_frame("rst_frame", 64'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Full frame 1..8 back to back
        for (int i = 1; i <= 7; i++) send(8'(i), 1'b0);
        chk("full_cnt7", count, 7);
        chk("full_valid_early", out_valid, 0);
        send(8'd8, 1'b0);
        chk_frame("full_frame", 64'h01020304_05060708);
        chk("full_valid", out_valid, 1);
        chk("full_short", out_short, 0);
        chk("full_count", count, 8);
        chk("full_in_ready", in_ready, 0);
        release_frame();
        chk("full_frame_cnt", frame_cnt, 1);
        chk("full_rel_valid", out_valid, 0);
        chk("full_rel_count", count, 0);
        chk_frame("full_rel_zero", 64'h0);
        chk("full_rel_in_ready", in_ready, 1);

        // Short frame
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b1);
        chk_frame("short_frame", 64'h10203000_00000000);
        chk("short_flag", out_short, 1);
        chk("short_count", count, 3);
        chk("short_valid", out_valid, 1);
        release_frame();
        chk("short_frame_cnt", frame_cnt, 2);
        chk("short_rel_flag", out_short, 0);

        // Backpressure: 0xFF offered while held must not enter
        for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), 1'b0);
        in_valid = 1'b1; in_data = 8'hFF;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_count", count, 8);
        chk_frame("bp_frame", 64'h11121314_15161718);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_frame_cnt", frame_cnt, 3);
        chk("bp_ff_dropped", count, 0);
        in_data = 8'h21;
        tick();
        in_valid = 1'b0;
        chk("bp_next_first", out_a, 8'h21);
        chk("bp_next_count", count, 1);

        // Flush with a coincident byte
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        send(8'h24, 1'b0);
        chk("fl_count4", count, 4);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        #1;
        chk("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_count", count, 0);
        chk_frame("fl_zero", 64'h0);
        // A0..A7 with idle gaps of 0..3 cycles
        for (int i = 0; i < 8; i++) begin
            send(8'hA0 + 8'(i), 1'b0);
            if (i != 7) for (int g = 0; g < (i % 4); g++) tick();
        end
        chk_frame("fl_frame", 64'hA0A1A2A3_A4A5A6A7);
        chk("fl_short", out_short, 0);
        release_frame();
        chk("fl_frame_cnt", frame_cnt, 4);

        // in_last on the 8th element is a full frame
        for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), i == 7);
        chk("last8_short", out_short, 0);
        chk("last8_count", count, 8);
        chk("last8_valid", out_valid, 1);
        release_frame();
        chk("last8_frame_cnt", frame_cnt, 5);

        // in_last without accept, out_ready in FILL: both no effect
        in_last = 1'b1;
        out_ready = 1'b1;
        tick();
        in_last = 1'b0;
        out_ready = 1'b0;
        chk("idle_last_valid", out_valid, 0);
        chk("idle_last_count", count, 0);
        chk("fill_ordy_cnt", frame_cnt, 5);

        // flush while holding is ignored
        for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("hflush_valid", out_valid, 1);
        chk_frame("hflush_frame", 64'h60616263_64656667);
        release_frame();
        chk("hflush_frame_cnt", frame_cnt, 6);

        // Asynchronous reset mid-fill, away from any edge
        for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk_frame("arst_frame", 64'h0);
        chk("arst_frame_cnt", frame_cnt, 0);
        chk("arst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) send(8'h31 + 8'(i), 1'b0);
        chk_frame("arst_new_frame", 64'h31323334_35363738);
        release_frame();
        chk("arst_new_cnt", frame_cnt, 1);

        // Counter wrap: 15 more transfers -> 16 mod 16 = 0
        for (int i = 0; i < 14; i++) begin
            send(8'h01, 1'b1);
            release_frame();
        end
        chk("wrap_cnt15", frame_cnt, 15);
        send(8'h01, 1'b1);
        release_frame();
        chk("wrap_cnt0", frame_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/m8_frame_loader.md
Name: m8_frame_loader

Overview:
- Upstream feeder for the 8-input combinational descending sorter (m8).
- Accepts a byte stream over a valid/ready handshake and packs 8 consecutive bytes into one frame.
- Holds the frame stable on eight parallel outputs until the consumer acknowledges it; out_a..out_h wire directly to the sorter's A..H.
- Supports short frames (zero-padded, so padding sorts to the bottom) and abort of a partial frame.

Parameters:
- WIDTH, 8, bit width of each element (matches the sorter data width).
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  stream element.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- in_last  input  1  marks final element of a frame; qualified by in_valid&&in_ready.
- flush  input  1  synchronous abort of the partial frame.
- out_a..out_h  output  WIDTH each  frame slots 0..7 in arrival order; 8 ports total.
- out_valid  output  1  frame is complete and stable.
- out_ready  input  1  consumer takes the frame.
- out_short  output  1  frame ended by in_last with fewer than 8 elements; valid with out_valid.
- count  output  4  elements in current frame, 0..8.
- frame_cnt  output  CNT_W  completed handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate): state=FILL, all slots=0, count=0, out_valid=0, out_short=0, frame_cnt=0, in_ready=0 while rst high.
- Accept event = in_valid && in_ready. Transfer event = out_valid && out_ready.
- States:
  - FILL: in_ready = !flush.
  - HOLD: in_ready=0, out_valid=1.
- FILL, on accept:
  - slot[count] <= in_data; count <= count+1.
  - Slot order: out_a first, out_h eighth.
- FILL -> HOLD on the accept that makes count==8, or on any accept with in_last=1.
  - out_valid rises on the next clock edge, so latency from the final accept to out_valid is 1 cycle.
  - out_short <= 1 only if the final count < 8.
  - in_last on the 8th element gives out_short=0.
- In FILL, in_last on an element is ignored when no accept occurs.
- Unfilled slots in a short frame read 0; slots are zeroed when each frame is released.
- HOLD:
  - Outputs and count are frozen; in_data/in_valid are ignored.
  - Frame is held indefinitely while out_ready=0.
- HOLD -> FILL on transfer, at the same edge:
  - all slots <= 0, count <= 0, out_valid <= 0, out_short <= 0, frame_cnt <= frame_cnt+1.
  - in_ready reasserts the following cycle.
  - Minimum period per full frame: 9 cycles.
- flush in FILL: slots <= 0, count <= 0, no state change. in_ready=0 that cycle, so a coincident in_valid is dropped and is not sampled later.
- flush in HOLD: ignored; the committed frame is still delivered.
- out_ready while in FILL: no effect.
- Gaps in in_valid are allowed; no timeout.
- Reset mid-fill or mid-hold: the frame is discarded and frame_cnt clears.
- No combinational path from in_valid to in_ready.
- in_ready depends only on state and flush.
- out_valid is registered.

Test Plan:
- Full frame: bytes 1..8 on back-to-back cycles, out_ready=1 -> one cycle after the 8th accept: out_a..out_h=1..8, out_valid=1, out_short=0, count=8; frame_cnt=1 after transfer; sorter sees y1..y8=8..1.
- Short frame: 0x10, 0x20, 0x30 with in_last on 0x30 -> outputs 10,20,30,0,0,0,0,0 (hex), out_short=1, count=3.
- Backpressure: full frame, then out_ready=0 for 5 cycles with in_valid=1 and in_data=0xFF -> out_valid stays 1, outputs unchanged, in_ready=0, no 0xFF captured; out_ready=1 -> transfer, next frame starts with the next offered byte.
- Flush: 4 bytes accepted, then flush asserted with in_valid=1 and in_data=0x55 -> count=0, 0x55 dropped; then 8 bytes 0xA0..0xA7 -> clean frame A0..A7.
- Async reset: assert rst mid-cycle after 5 bytes, with no clock edge -> all outputs 0 immediately; after release, 8 new bytes -> correct frame, frame_cnt=1 after transfer.
- Boundaries: in_last on the 8th byte -> out_short=0. Stall gaps of 0–3 cycles between bytes -> same result as back-to-back. 2^CNT_W transfers (CNT_W reduced to 4 in the bench) -> frame_cnt wraps to 0.
